// File: rtl/fp_align_add_stage_pkg.sv
// Shared definitions for the single-precision adder pipeline: field widths,
// the unpacked-operand and stage-1 payload structs, and the unpack helper.
package fp_add_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = 26;

    // One operand after unpacking: sign, biased exponent and a significand
    // with two guard zeros on top, then the hidden bit, then the mantissa.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp_unpacked_t;

    // Everything stage 2 needs about the ordered operand pair.
    typedef struct packed {
        logic             l_sign;
        logic             s_sign;
        logic [EXP_W-1:0] l_exp;
        logic [EXP_W-1:0] diff;
        logic [SIG_W-1:0] l_sig;
        logic [SIG_W-1:0] s_sig;
    } s1_payload_t;

    // Split an IEEE-754 single into fields; exponent 0 gets a hidden bit of 0.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] op);
        fp_unpacked_t u;
        u.sign = op[31];
        u.exp  = op[30:23];
        u.sig  = {2'b00, (op[30:23] != 8'd0), op[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_align_add_stage_unpack.sv
// Combinational unpack of one single-precision operand.
module fp_unpack18
    import fp_add_pkg::*;
(
    input  logic [31:0]  op,
    output fp_unpacked_t unp
);

    // Pure field extraction; no denormal, NaN or Inf special-casing.
    always_comb begin
        unp = fp_unpack(op);
    end

endmodule

// File: rtl/fp_align_add_stage.sv
// Front half of the pipelined single-precision adder: orders the operands by
// exponent, aligns the smaller one and adds the signed significands. Two
// register stages with valid/ready on both sides, one pair per cycle.
module fp_align_add_stage
    import fp_add_pkg::*;
(
    input  logic             clk18,
    input  logic             rst_n18,
    input  logic             in_valid18,
    output logic             in_ready18,
    input  logic [31:0]      a18,
    input  logic [31:0]      b18,
    output logic             out_valid18,
    input  logic             out_ready18,
    output logic [EXP_W-1:0] out_exp18,
    output logic [SIG_W-1:0] out_sig18
);

    logic             s1_valid_r;
    s1_payload_t      s1_r;
    logic             out_valid_r;
    logic [EXP_W-1:0] out_exp_r;
    logic [SIG_W-1:0] out_sig_r;

    logic             s2_ready_s;
    logic             in_xfer_s;
    logic             s12_xfer_s;
    logic             swap_s;
    logic [31:0]      l_op_s;
    logic [31:0]      s_op_s;
    fp_unpacked_t     l_unp_s;
    fp_unpacked_t     s_unp_s;
    s1_payload_t      s1_next_s;
    logic [SIG_W-1:0] s_shift_s;
    logic [SIG_W-1:0] l_signed_s;
    logic [SIG_W-1:0] s_signed_s;
    logic [SIG_W-1:0] sum_s;

    // Handshake: S2 frees up when empty or draining; S1 can take a pair when
    // empty or when its content moves into S2 on the same edge.
    assign s2_ready_s  = !out_valid_r || out_ready18;
    assign in_ready18  = !s1_valid_r || s2_ready_s;
    assign in_xfer_s   = in_valid18 && in_ready18;
    assign s12_xfer_s  = s1_valid_r && s2_ready_s;

    assign out_valid18 = out_valid_r;
    assign out_exp18   = out_exp_r;
    assign out_sig18   = out_sig_r;

    // Order operands so L has the larger exponent; ties keep A as L.
    always_comb begin
        swap_s = (a18[30:23] < b18[30:23]);
        if (swap_s) begin
            l_op_s = b18;
            s_op_s = a18;
        end else begin
            l_op_s = a18;
            s_op_s = b18;
        end
    end

    fp_unpack18 u_unpack_l (
        .op  (l_op_s),
        .unp (l_unp_s)
    );

    fp_unpack18 u_unpack_s (
        .op  (s_op_s),
        .unp (s_unp_s)
    );

    // Assemble the S1 payload; diff cannot wrap because L.exp >= S.exp.
    always_comb begin
        s1_next_s.l_sign = l_unp_s.sign;
        s1_next_s.s_sign = s_unp_s.sign;
        s1_next_s.l_exp  = l_unp_s.exp;
        s1_next_s.diff   = l_unp_s.exp - s_unp_s.exp;
        s1_next_s.l_sig  = l_unp_s.sig;
        s1_next_s.s_sig  = s_unp_s.sig;
    end

    // Stage 1 register: valid follows the input whenever S1 is free to move.
    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '{default: '0};
        end else begin
            if (in_ready18) begin
                s1_valid_r <= in_valid18;
            end
            if (in_xfer_s) begin
                s1_r <= s1_next_s;
            end
        end
    end

    // Align the smaller significand; shifted-out bits are simply dropped.
    always_comb begin
        if (s1_r.diff >= EXP_W'(SIG_W)) begin
            s_shift_s = {SIG_W{1'b0}};
        end else begin
            s_shift_s = s1_r.s_sig >> s1_r.diff;
        end
    end

    // Apply signs as 26-bit two's complement and add modulo 2^26.
    always_comb begin
        if (s1_r.l_sign) begin
            l_signed_s = ~s1_r.l_sig + SIG_W'(1);
        end else begin
            l_signed_s = s1_r.l_sig;
        end
        if (s1_r.s_sign) begin
            s_signed_s = ~s_shift_s + SIG_W'(1);
        end else begin
            s_signed_s = s_shift_s;
        end
        sum_s = l_signed_s + s_signed_s;
    end

    // Stage 2 register: results hold while the downstream stage stalls.
    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            out_valid_r <= 1'b0;
            out_exp_r   <= {EXP_W{1'b0}};
            out_sig_r   <= {SIG_W{1'b0}};
        end else begin
            if (s2_ready_s) begin
                out_valid_r <= s1_valid_r;
            end
            if (s12_xfer_s) begin
                out_exp_r <= s1_r.l_exp;
                out_sig_r <= sum_s;
            end
        end
    end

endmodule
